// File: rtl/spi_master.sv
// spi_master: mode-0 SPI bus initiator, one BufferSize-bit word per transfer, MSB first.
// Optional word chaining with ss held low is enabled by defining SPI_MASTER_BURST_EN.
`default_nettype none

module spi_master #(
  parameter int BufferSize   = 8,
  parameter int ClockDivider = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [BufferSize-1:0] txData,
`ifdef SPI_MASTER_BURST_EN
  input  logic                  keepSelected,
`endif
  output logic [BufferSize-1:0] rxData,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int          CntW     = $clog2(BufferSize + 1);
  localparam logic [15:0] DivLast  = 16'(ClockDivider - 1);
  localparam logic [CntW-1:0] LastBit = CntW'(BufferSize);

`ifdef SPI_MASTER_BURST_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    HIGH    = 3'd2,
    LOW     = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5,
    CHAINED = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;
`endif

  state_t                state;
  logic [15:0]           div_cnt;
  logic [CntW-1:0]       bit_cnt;
  logic [BufferSize-1:0] tx_sr;
  logic [BufferSize-1:0] rx_sr;
  logic                  div_end;
`ifdef SPI_MASTER_BURST_EN
  // Set when HOLD is entered from CHAINED: that word was already reported.
  logic                  quiet;
`endif

  assign div_end = (div_cnt == DivLast);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      div_cnt <= 16'd0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rxData  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      quiet   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= txData;
            mosi    <= txData[BufferSize-1];
            ss      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= 16'd0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end

        // Both phases end on the edge that raises sck and samples miso.
        SETUP, LOW: begin
          if (div_end) begin
            div_cnt <= 16'd0;
            sck     <= 1'b1;
            rx_sr   <= {rx_sr[BufferSize-2:0], miso};
            bit_cnt <= bit_cnt + CntW'(1);
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        HIGH: begin
          if (div_end) begin
            div_cnt <= 16'd0;
            sck     <= 1'b0;
            if (bit_cnt == LastBit) begin
`ifdef SPI_MASTER_BURST_EN
              if (keepSelected) begin
                rxData <= rx_sr;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= CHAINED;
              end else begin
                state  <= HOLD;
              end
`else
              state <= HOLD;
`endif
            end else begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[BufferSize-2];
              state <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        HOLD: begin
          if (div_end) begin
            div_cnt <= 16'd0;
            ss      <= 1'b1;
            mosi    <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            if (!quiet) begin
              rxData <= rx_sr;
              done   <= 1'b1;
            end
            quiet <= 1'b0;
`else
            rxData <= rx_sr;
            done   <= 1'b1;
`endif
            state <= GAP;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        GAP: begin
          if (div_end) begin
            div_cnt <= 16'd0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

`ifdef SPI_MASTER_BURST_EN
        CHAINED: begin
          if (start) begin
            tx_sr   <= txData;
            mosi    <= txData[BufferSize-1];
            busy    <= 1'b1;
            div_cnt <= 16'd0;
            bit_cnt <= '0;
            state   <= SETUP;
          end else if (!keepSelected) begin
            busy    <= 1'b1;
            div_cnt <= 16'd0;
            quiet   <= 1'b1;
            state   <= HOLD;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed checks of spi_master against a slave model.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master;

  localparam int B = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         resetN;
  logic         start, start1;
  logic [B-1:0] txData, tx1;
  logic [B-1:0] rxData, rx1;
  logic         busy, done, sck, ss, mosi, miso;
  logic         busy1, done1, sck1, ss1, mosi1, miso1;
  logic         loop;
  logic         keepSelected;

  always #5 clk = ~clk;

  spi_master #(.BufferSize(B), .ClockDivider(D)) dut (
    .clk(clk), .resetN(resetN), .start(start), .txData(txData),
`ifdef SPI_MASTER_BURST_EN
    .keepSelected(keepSelected),
`endif
    .rxData(rxData), .busy(busy), .done(done), .sck(sck), .ss(ss),
    .mosi(mosi), .miso(miso)
  );

  spi_master #(.BufferSize(B), .ClockDivider(1)) dut1 (
    .clk(clk), .resetN(resetN), .start(start1), .txData(tx1),
`ifdef SPI_MASTER_BURST_EN
    .keepSelected(1'b0),
`endif
    .rxData(rx1), .busy(busy1), .done(done1), .sck(sck1), .ss(ss1),
    .mosi(mosi1), .miso(miso1)
  );

  assign miso1 = mosi1;

  // Mode-0 slave: loads its word when selected, shifts out on sck fall, captures on sck rise.
  logic [B-1:0] s_word, s_out, s_rx;
  always @(negedge ss) s_out <= s_word;
  always @(negedge sck) if (!ss) s_out <= {s_out[B-2:0], 1'b0};
  always @(posedge sck) if (!ss) s_rx <= {s_rx[B-2:0], mosi};
  assign miso = loop ? mosi : s_out[B-1];

  // mosi may only move while sck is low, and must be 0 while deselected.
  int   viol = 0;
  logic pmosi = 1'b0;
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (mosi !== pmosi && sck === 1'b1) viol++;
      if (ss === 1'b1 && mosi !== 1'b0) viol++;
    end
    pmosi = mosi;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer on dut, sampled mid-cycle from the cycle after start until busy drops.
  task automatic run_xfer(input logic [B-1:0] tx, output int ss_lo, output int busy_hi,
                          output int rises, output int dones, output logic [B-1:0] rx_at_done);
    logic psck;
    ss_lo = 0; busy_hi = 0; rises = 0; dones = 0; rx_at_done = '0; psck = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    txData = tx;
    @(negedge clk);
    start  = 1'b0;
    txData = B'($urandom);
    for (int n = 0; n < 400; n++) begin
      if (!ss) ss_lo++;
      if (busy) busy_hi++;
      if (sck && !psck) rises++;
      if (done) begin
        dones++;
        rx_at_done = rxData;
      end
      psck = sck;
      if (!busy) break;
      @(negedge clk);
    end
    chk("xfer_end_busy", busy, 0);
  endtask

  int ss_lo, busy_hi, rises, dones, gapmin, run, lo, tog, ex, sshi;
  logic [B-1:0] rxd, tx, sw;
  logic seen_low, p;

  initial begin
    resetN = 1'b0; start = 1'b0; txData = '0; start1 = 1'b0; tx1 = '0;
    loop = 1'b1; s_word = '0; keepSelected = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss", ss, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rxData", rxData, 0);
    resetN = 1'b1;
    @(negedge clk);

    // Loopback 0xA5
    loop = 1'b1;
    run_xfer(8'hA5, ss_lo, busy_hi, rises, dones, rxd);
    chk("a5_ss_low", ss_lo, (2 * B + 1) * D);
    chk("a5_busy", busy_hi, (2 * B + 2) * D);
    chk("a5_rises", rises, B);
    chk("a5_dones", dones, 1);
    chk("a5_rx_at_done", rxd, 8'hA5);
    chk("a5_rxData", rxData, 8'hA5);

    // Slave returning 0x3C
    loop = 1'b0; s_word = 8'h3C;
    run_xfer(8'hC3, ss_lo, busy_hi, rises, dones, rxd);
    chk("slv_captured", s_rx, 8'hC3);
    chk("slv_rxData", rxData, 8'h3C);
    chk("slv_dones", dones, 1);

    // Random words both directions
    for (int i = 0; i < 6; i++) begin
      sw = B'($urandom); tx = B'($urandom);
      s_word = sw;
      run_xfer(tx, ss_lo, busy_hi, rises, dones, rxd);
      chk("rnd_rx", rxd, sw);
      chk("rnd_slave", s_rx, tx);
      chk("rnd_ss_low", ss_lo, (2 * B + 1) * D);
      chk("rnd_rises", rises, B);
    end
    chk("mosi_stable", viol, 0);

    // start held for 200 cycles
    loop = 1'b1;
    @(negedge clk);
    txData = 8'h11; start = 1'b1;
    dones = 0; run = 0; gapmin = 100000; seen_low = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (ss) run++;
      else begin
        if (run > 0 && seen_low && run < gapmin) gapmin = run;
        run = 0;
        seen_low = 1'b1;
      end
    end
    start = 1'b0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    chk("held_dones", dones, 2);
    chk("held_gap_ge4", (gapmin >= 4 && gapmin < 100000), 1);
    chk("held_idle", busy, 0);
    chk("held_rx", rxData, 8'h11);

    // Reset after third sck rising edge
    @(negedge clk);
    start = 1'b1; txData = 8'h77;
    @(negedge clk);
    start = 1'b0;
    rises = 0; p = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sck && !p) rises++;
      p = sck;
      if (rises == 3) break;
      @(negedge clk);
    end
    chk("mid_rises", rises, 3);
    resetN = 1'b0;
    #1;
    chk("mid_ss", ss, 1);
    chk("mid_sck", sck, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rxData", rxData, 0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    resetN = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_no_done", dones, 0);
    chk("mid_idle_busy", busy, 0);
    run_xfer(8'h5A, ss_lo, busy_hi, rises, dones, rxd);
    chk("post_rst_rx", rxData, 8'h5A);
    chk("post_rst_dones", dones, 1);

    // ClockDivider=1 instance, loopback 0xFF
    @(negedge clk);
    start1 = 1'b1; tx1 = 8'hFF;
    @(negedge clk);
    start1 = 1'b0; tx1 = '0;
    lo = 0; tog = 0; rises = 0; p = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (!ss1) begin
        lo++;
        if (sck1 !== p) tog++;
      end
      if (sck1 && !p) rises++;
      p = sck1;
      if (!busy1) break;
      @(negedge clk);
    end
    chk("d1_ss_low", lo, 2 * B + 1);
    chk("d1_toggles", tog, 2 * B);
    chk("d1_rises", rises, B);
    chk("d1_rx", rx1, 8'hFF);
    chk("d1_idle", busy1, 0);

`ifdef SPI_MASTER_BURST_EN
    loop = 1'b1; keepSelected = 1'b1; sshi = 0;
    @(negedge clk);
    start = 1'b1; txData = 8'h12;
    @(negedge clk);
    start = 1'b0; txData = 8'h34;
    for (int n = 0; n < 300 && !done; n++) begin
      if (ss) sshi++;
      @(negedge clk);
    end
    chk("burst_rx1", rxData, 8'h12);
    chk("burst_ss1", ss, 0);
    chk("burst_busy1", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (ss) sshi++;
      @(negedge clk);
    end
    chk("burst_rx2", rxData, 8'h34);
    chk("burst_ss_held", sshi, 0);
    keepSelected = 1'b0;
    @(negedge clk);
    lo = 0; ex = 0;
    for (int n = 0; n < 100; n++) begin
      if (!ss) lo++;
      if (done) ex++;
      if (!busy) break;
      @(negedge clk);
    end
    chk("burst_hold_len", lo, D);
    chk("burst_no_extra_done", ex, 0);
    chk("burst_ss_end", ss, 1);
    chk("burst_rx_kept", rxData, 8'h34);
`endif

    chk("mosi_stable_end", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
